// File: rtl/fmap_maxpool_reader.sv
// Reads a held SIZE x SIZE signed feature map and streams non-overlapping
// POOL x POOL max-pooled results, with their coordinates, over valid/ready.
module fmap_maxpool_reader #(
  parameter int SIZE      = 318,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 16
) (
  input  logic                                 clock,
  input  logic                                 nreset,
  input  logic                                 start,
  input  logic signed [WIDTH_BIT-1:0]          inpMatrixI [SIZE-1:0][SIZE-1:0],
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [WIDTH_BIT-1:0]          out_data,
  output logic [$clog2(SIZE/POOL+1)-1:0]       out_row,
  output logic [$clog2(SIZE/POOL+1)-1:0]       out_col,
  output logic                                 busy,
  output logic                                 done
);

  localparam int OSIZE = SIZE / POOL;
  localparam int CW    = $clog2(OSIZE + 1);
  localparam int KW    = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST_RC = CW'(OSIZE - 1);
  localparam logic [KW-1:0] LAST_K  = KW'(POOL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_row;
  logic [CW-1:0]               r_col;
  logic [KW-1:0]               r_kRow;
  logic [KW-1:0]               r_kCol;
  logic signed [WIDTH_BIT-1:0] r_max;

  logic [IW-1:0]               w_rowIdx;
  logic [IW-1:0]               w_colIdx;
  logic signed [WIDTH_BIT-1:0] w_elem;
  logic signed [WIDTH_BIT-1:0] w_newMax;
  logic                        w_firstK;
  logic                        w_lastK;

  // The window offset k is kept as (kRow, kCol) so no divide/modulo is needed.
  assign w_rowIdx = IW'(r_row) * IW'(POOL) + IW'(r_kRow);
  assign w_colIdx = IW'(r_col) * IW'(POOL) + IW'(r_kCol);
  assign w_elem   = inpMatrixI[w_rowIdx][w_colIdx];
  assign w_firstK = (r_kRow == '0) && (r_kCol == '0);
  assign w_lastK  = (r_kRow == LAST_K) && (r_kCol == LAST_K);
  // Strictly-greater replacement keeps the earlier value on ties.
  assign w_newMax = w_firstK ? w_elem : ((w_elem > r_max) ? w_elem : r_max);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_kRow    <= '0;
      r_kCol    <= '0;
      r_max     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_kRow  <= '0;
            r_kCol  <= '0;
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_max <= w_newMax;
          if (w_lastK) begin
            out_data  <= w_newMax;
            out_row   <= r_row;
            out_col   <= r_col;
            out_valid <= 1'b1;
            r_kRow    <= '0;
            r_kCol    <= '0;
            r_state   <= EMIT;
          end else if (r_kCol == LAST_K) begin
            r_kCol <= '0;
            r_kRow <= r_kRow + KW'(1);
          end else begin
            r_kCol <= r_kCol + KW'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r_col < LAST_RC) begin
              r_col   <= r_col + CW'(1);
              r_state <= LOAD;
            end else if (r_row < LAST_RC) begin
              r_col   <= '0;
              r_row   <= r_row + CW'(1);
              r_state <= LOAD;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= FIN;
            end
          end
        end
        FIN: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_maxpool_reader.sv
// Self-checking bench: two instances (4x4 and 5x5 maps, 2x2 pooling) compared
// against a plain-arithmetic max-pool reference model.
module tb_fmap_maxpool_reader;

  localparam int W = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic nreset;
  logic start4, start5, outReady;
  logic signed [W-1:0] map4 [3:0][3:0];
  logic signed [W-1:0] map5 [4:0][4:0];

  logic v4, b4, dn4, v5, b5, dn5;
  logic signed [W-1:0] d4, d5;
  logic [1:0] r4, c4, r5, c5;

  fmap_maxpool_reader #(.SIZE(4), .POOL(2), .WIDTH_BIT(W)) dut4 (
    .clock(clock), .nreset(nreset), .start(start4), .inpMatrixI(map4),
    .out_valid(v4), .out_ready(outReady), .out_data(d4), .out_row(r4),
    .out_col(c4), .busy(b4), .done(dn4)
  );

  fmap_maxpool_reader #(.SIZE(5), .POOL(2), .WIDTH_BIT(W)) dut5 (
    .clock(clock), .nreset(nreset), .start(start5), .inpMatrixI(map5),
    .out_valid(v5), .out_ready(outReady), .out_data(d5), .out_row(r5),
    .out_col(c5), .busy(b5), .done(dn5)
  );

  int sel;
  logic obsValid, obsBusy, obsDone;
  logic signed [W-1:0] obsData;
  logic [1:0] obsRow, obsCol;
  assign obsValid = (sel == 0) ? v4 : v5;
  assign obsBusy  = (sel == 0) ? b4 : b5;
  assign obsDone  = (sel == 0) ? dn4 : dn5;
  assign obsData  = (sel == 0) ? d4 : d5;
  assign obsRow   = (sel == 0) ? r4 : r5;
  assign obsCol   = (sel == 0) ? c4 : c5;

  int checks = 0;
  int errors = 0;

  int refMap [5][5];
  int expData [4];
  int expRow [4];
  int expCol [4];
  int nExp;

  int gotData [$];
  int gotRow [$];
  int gotCol [$];
  int firstValidCycle, doneCount, doneCycle, lastHsCycle, stallErrs, busyAtDone, timedOut;

  // Reference: max over each 2x2 window, row-major window order.
  function automatic void buildModel(input int sz);
    int osz;
    int m;
    osz  = sz / 2;
    nExp = 0;
    for (int r = 0; r < osz; r++) begin
      for (int c = 0; c < osz; c++) begin
        m = refMap[2*r][2*c];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (refMap[2*r+dr][2*c+dc] > m) m = refMap[2*r+dr][2*c+dc];
        expData[nExp] = m;
        expRow[nExp]  = r;
        expCol[nExp]  = c;
        nExp++;
      end
    end
  endfunction

  task automatic applyMap(input int sz);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (sz == 4 && r < 4 && c < 4) map4[r][c] = 16'(refMap[r][c]);
        if (sz == 5) map5[r][c] = 16'(refMap[r][c]);
      end
  endtask

  task automatic driveStart(input int which, input logic v);
    if (which == 0) start4 = v;
    else start5 = v;
  endtask

  // Runs one frame on the selected instance and records what came out.
  task automatic runFrame(input int which, input int readyMode, input int inject,
                          input int restart, input int noStart);
    int c;
    int extra;
    logic prevStall;
    logic signed [W-1:0] hData;
    logic [1:0] hRow, hCol;
    sel = which;
    gotData.delete(); gotRow.delete(); gotCol.delete();
    firstValidCycle = -1; doneCount = 0; doneCycle = -1; lastHsCycle = -1;
    stallErrs = 0; busyAtDone = -1; timedOut = 0;
    c = 0; extra = 0; prevStall = 1'b0; hData = '0; hRow = '0; hCol = '0;
    if (noStart == 0) begin
      driveStart(which, 1'b1);
      @(posedge clock); #1;
      driveStart(which, 1'b0);
    end
    forever begin
      case (readyMode)
        0: outReady = 1'b1;
        1: outReady = (((c + 1) / 3) % 2) == 1;
        default: outReady = ($urandom_range(0, 9) < 6);
      endcase
      if (inject != 0 && (c + 1 == 2 || c + 1 == 5 || c + 1 == 8)) driveStart(which, 1'b1);
      @(negedge clock);
      c++;
      if (prevStall && (obsValid !== 1'b1 || obsData !== hData || obsRow !== hRow || obsCol !== hCol))
        stallErrs++;
      if (obsValid === 1'b1 && firstValidCycle < 0) firstValidCycle = c;
      if (obsValid === 1'b1 && outReady) begin
        gotData.push_back(int'(obsData));
        gotRow.push_back(int'(obsRow));
        gotCol.push_back(int'(obsCol));
        lastHsCycle = c;
      end
      prevStall = (obsValid === 1'b1) && !outReady;
      hData = obsData; hRow = obsRow; hCol = obsCol;
      if (obsDone === 1'b1) begin
        doneCount++;
        doneCycle  = c;
        busyAtDone = (obsBusy === 1'b1) ? 1 : 0;
      end
      @(posedge clock); #1;
      driveStart(which, 1'b0);
      if (doneCount > 0) begin
        if (restart != 0) begin
          driveStart(which, 1'b1);
          @(posedge clock); #1;
          driveStart(which, 1'b0);
          break;
        end
        extra++;
        if (extra >= 4) break;
      end
      if (c >= 400) begin
        timedOut = 1;
        break;
      end
    end
    outReady = 1'b0;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (v4 !== 1'b0 || v5 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b, expected 0/0", v4, v5); end
    checks++; if (b4 !== 1'b0 || b5 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b, expected 0/0", b4, b5); end
    checks++; if (dn4 !== 1'b0 || dn5 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b, expected 0/0", dn4, dn5); end
    checks++; if (d4 !== 16'sd0 || r4 !== 2'd0 || c4 !== 2'd0) begin errors++; $display("FAIL reset_outputs: got data=%0d row=%0d col=%0d, expected 0 0 0", d4, r4, c4); end
    @(posedge clock); #1;
    nreset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_basic;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) refMap[r][c] = (r < 4 && c < 4) ? r * 4 + c : 0;
    applyMap(4); buildModel(4);
    runFrame(0, 0, 0, 0, 0);
    checks++; if (timedOut != 0) begin errors++; $display("FAIL basic_timeout: got %0d, expected 0", timedOut); end
    checks++; if (gotData.size() != nExp) begin errors++; $display("FAIL basic_count: got %0d, expected %0d", gotData.size(), nExp); end
    for (int i = 0; i < nExp && i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] != expData[i] || gotRow[i] != expRow[i] || gotCol[i] != expCol[i]) begin
        errors++;
        $display("FAIL basic_elem[%0d]: got %0d@(%0d,%0d), expected %0d@(%0d,%0d)", i, gotData[i], gotRow[i], gotCol[i], expData[i], expRow[i], expCol[i]);
      end
    end
    checks++; if (firstValidCycle != 5) begin errors++; $display("FAIL basic_latency: got %0d, expected 5", firstValidCycle); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL basic_done_count: got %0d, expected 1", doneCount); end
    checks++; if (doneCycle != lastHsCycle + 1) begin errors++; $display("FAIL basic_done_timing: got %0d, expected %0d", doneCycle, lastHsCycle + 1); end
    checks++; if (busyAtDone != 0) begin errors++; $display("FAIL basic_busy_at_done: got %0d, expected 0", busyAtDone); end
  endtask

  task automatic test_stall;
    runFrame(0, 1, 0, 0, 0);
    checks++; if (timedOut != 0 || gotData.size() != nExp) begin errors++; $display("FAIL stall_count: got %0d (timeout %0d), expected %0d", gotData.size(), timedOut, nExp); end
    for (int i = 0; i < nExp && i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] != expData[i] || gotRow[i] != expRow[i] || gotCol[i] != expCol[i]) begin
        errors++;
        $display("FAIL stall_elem[%0d]: got %0d@(%0d,%0d), expected %0d@(%0d,%0d)", i, gotData[i], gotRow[i], gotCol[i], expData[i], expRow[i], expCol[i]);
      end
    end
    checks++; if (stallErrs != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles, expected 0", stallErrs); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL stall_done_count: got %0d, expected 1", doneCount); end
  endtask

  task automatic test_signed;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) refMap[r][c] = -7;
    refMap[3][2] = -1;
    applyMap(4); buildModel(4);
    runFrame(0, 0, 0, 0, 0);
    checks++; if (timedOut != 0 || gotData.size() != nExp) begin errors++; $display("FAIL signed_count: got %0d, expected %0d", gotData.size(), nExp); end
    for (int i = 0; i < nExp && i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] != expData[i]) begin errors++; $display("FAIL signed_elem[%0d]: got %0d, expected %0d", i, gotData[i], expData[i]); end
    end
  endtask

  task automatic test_trailing;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) refMap[r][c] = (r == 4 || c == 4) ? 32767 : 1;
    applyMap(5); buildModel(5);
    runFrame(1, 0, 0, 0, 0);
    checks++; if (timedOut != 0 || gotData.size() != 4) begin errors++; $display("FAIL trailing_count: got %0d, expected 4", gotData.size()); end
    for (int i = 0; i < nExp && i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] != expData[i] || gotRow[i] != expRow[i] || gotCol[i] != expCol[i]) begin
        errors++;
        $display("FAIL trailing_elem[%0d]: got %0d@(%0d,%0d), expected %0d@(%0d,%0d)", i, gotData[i], gotRow[i], gotCol[i], expData[i], expRow[i], expCol[i]);
      end
    end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL trailing_done_count: got %0d, expected 1", doneCount); end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) refMap[r][c] = (r < 4 && c < 4) ? r * 4 + c : 0;
    applyMap(4); buildModel(4);
    runFrame(0, 0, 1, 1, 0);
    checks++; if (timedOut != 0 || gotData.size() != nExp) begin errors++; $display("FAIL b2b_first_count: got %0d, expected %0d", gotData.size(), nExp); end
    for (int i = 0; i < nExp && i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] != expData[i]) begin errors++; $display("FAIL b2b_first_elem[%0d]: got %0d, expected %0d", i, gotData[i], expData[i]); end
    end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL b2b_first_done: got %0d, expected 1", doneCount); end
    runFrame(0, 0, 0, 0, 1);
    checks++; if (timedOut != 0 || gotData.size() != nExp) begin errors++; $display("FAIL b2b_second_count: got %0d, expected %0d", gotData.size(), nExp); end
    checks++; if (firstValidCycle != 5) begin errors++; $display("FAIL b2b_second_latency: got %0d, expected 5", firstValidCycle); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL b2b_second_done: got %0d, expected 1", doneCount); end
  endtask

  task automatic test_reset_mid;
    int seen;
    int bad;
    sel = 0; outReady = 1'b0; seen = 0; bad = 0;
    driveStart(0, 1'b1);
    @(posedge clock); #1;
    driveStart(0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (v4 === 1'b1) begin seen = 1; break; end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL rstmid_valid_seen: got %0d, expected 1", seen); end
    checks++; if (int'(d4) != expData[0]) begin errors++; $display("FAIL rstmid_pre_data: got %0d, expected %0d", d4, expData[0]); end
    #2 nreset = 1'b0;
    #1;
    checks++; if (v4 !== 1'b0 || b4 !== 1'b0 || dn4 !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got v=%b b=%b d=%b, expected 0 0 0", v4, b4, dn4); end
    checks++; if (d4 !== 16'sd0 || r4 !== 2'd0 || c4 !== 2'd0) begin errors++; $display("FAIL rstmid_data: got %0d (%0d,%0d), expected 0 (0,0)", d4, r4, c4); end
    @(posedge clock); #1;
    nreset = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (v4 !== 1'b0 || b4 !== 1'b0 || dn4 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_idle_after: got %0d active cycles, expected 0", bad); end
    @(posedge clock); #1;
    outReady = 1'b0;
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          refMap[r][c] = int'($urandom_range(0, 65535)) - 32768;
      applyMap(5); buildModel(5);
      runFrame(1, 2, 0, 0, 0);
      checks++; if (timedOut != 0 || gotData.size() != nExp) begin errors++; $display("FAIL rand%0d_count: got %0d, expected %0d", f, gotData.size(), nExp); end
      for (int i = 0; i < nExp && i < gotData.size(); i++) begin
        checks++;
        if (gotData[i] != expData[i] || gotRow[i] != expRow[i] || gotCol[i] != expCol[i]) begin
          errors++;
          $display("FAIL rand%0d_elem[%0d]: got %0d@(%0d,%0d), expected %0d@(%0d,%0d)", f, i, gotData[i], gotRow[i], gotCol[i], expData[i], expRow[i], expCol[i]);
        end
      end
      checks++; if (stallErrs != 0 || doneCount != 1) begin errors++; $display("FAIL rand%0d_protocol: got stall=%0d done=%0d, expected 0 1", f, stallErrs, doneCount); end
    end
  endtask

  initial begin
    nreset = 1'b0; start4 = 1'b0; start5 = 1'b0; outReady = 1'b0; sel = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        refMap[r][c] = 0;
        map5[r][c] = '0;
        if (r < 4 && c < 4) map4[r][c] = '0;
      end
    test_reset;
    test_basic;
    test_stall;
    test_signed;
    test_trailing;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
